// File: rtl/pipeline_stall_controller.sv
// Hazard and stall controller for a five-stage pipeline. It inserts a load-use
// bubble, flushes IF/ID on a taken branch, and freezes the whole pipeline while
// a data memory access is outstanding. A memory wait that runs too long is
// aborted and latched in a sticky flag. Two saturating counters record stall
// cycles and branch flushes.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RUN      | normal flow: memory freeze, then branch flush, then load-use
// MEM_WAIT | memory access outstanding; pipeline frozen until ready/timeout
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             sel,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  // Last frozen cycle index before the access is abandoned.
  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic mem_busy;
  logic load_use;
  logic flush_evt;

  assign mem_busy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready;
  assign load_use = ID_EX_MemRead & (ID_EX_rd != 5'd0) &
                    ((ID_EX_rd == IF_ID_rs1) | (ID_EX_rd == IF_ID_rs2));

  // Mealy pipeline controls and next-state / counter update.
  always_comb begin
    PCWrite        = 1'b1;
    IF_ID_Write    = 1'b1;
    IF_ID_Flush    = 1'b0;
    sel            = 1'b1;
    ID_EX_Write    = 1'b1;
    EX_MEM_Write   = 1'b1;
    flush_evt      = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;

    if (reset) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_busy) begin
            // A branch arriving now stays in EX and is flushed after release.
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            state_d      = MEM_WAIT;
            wait_cnt_d   = 8'd1;
          end else if (EX_branch_taken) begin
            IF_ID_Flush = 1'b1;
            sel         = 1'b0;
            flush_evt   = 1'b1;
          end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            sel         = 1'b0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
          end else begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            if (wait_cnt_q >= WAIT_LAST) begin
              mem_timeout_d = 1'b1;
              state_d       = RUN;
              wait_cnt_d    = 8'd0;
            end else begin
              wait_cnt_d = wait_cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end
      endcase
    end

    stall_cycles_d = stall_cycles_q;
    if (!PCWrite && (stall_cycles_q != CNT_MAX))
      stall_cycles_d = stall_cycles_q + 1'b1;

    flush_count_d = flush_count_q;
    if (flush_evt && (flush_count_q != CNT_MAX))
      flush_count_d = flush_count_q + 1'b1;
  end

  // State, wait counter, performance counters and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= 8'd0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      mem_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      mem_timeout_q  <= mem_timeout_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max cycles spent waiting on one memory access before abort (legal range 2..255).
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IF_ID_rs1  input  5  source register 1 of instruction in ID.
REQ-006 IF_ID_rs2  input  5  source register 2 of instruction in ID.
REQ-007 ID_EX_rd  input  5  destination register of instruction in EX.
REQ-008 ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-009 EX_branch_taken  input  1  branch/jump resolved taken in EX this cycle.
REQ-010 EX_MEM_MemRead  input  1  load in MEM stage.
REQ-011 EX_MEM_MemWrite  input  1  store in MEM stage.
REQ-012 mem_ready  input  1  data memory completes access this cycle.
REQ-013 PCWrite  output  1  PC update enable.
REQ-014 IF_ID_Write  output  1  IF/ID register load enable.
REQ-015 IF_ID_Flush  output  1  clear IF/ID to NOP.
REQ-016 sel  output  1  ID/EX control mux select; 1 = pass decoded controls, 0 = insert bubble.
REQ-017 ID_EX_Write  output  1  ID/EX register load enable.
REQ-018 EX_MEM_Write  output  1  EX/MEM register load enable.
REQ-019 mem_timeout  output  1  sticky flag, memory access aborted on timeout.
REQ-020 stall_cycles  output  CNT_W  count of cycles with PCWrite=0 outside reset.
REQ-021 flush_count  output  CNT_W  count of taken-branch flushes.

Function
REQ-022 FSM states: RUN, MEM_WAIT; state, wait counter (8-bit), counters, mem_timeout registered on clk.
REQ-023 Definitions: mem_busy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~mem_ready; load_use = ID_EX_MemRead & (ID_EX_rd != 0) & (ID_EX_rd == IF_ID_rs1 | ID_EX_rd == IF_ID_rs2).
REQ-024 Outputs combinational from state and current inputs (Mealy); default all enables 1, IF_ID_Flush 0, sel 1.
REQ-025 RUN priority 1, mem_busy: PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write = 0, sel 1, flush 0; next MEM_WAIT, wait counter <= 1.
REQ-026 RUN priority 2, EX_branch_taken: IF_ID_Flush 1, sel 0, all enables 1; next RUN; flush_count +1.
REQ-027 RUN priority 3, load_use: PCWrite 0, IF_ID_Write 0, sel 0, ID_EX_Write 1, EX_MEM_Write 1; next RUN (one-cycle bubble).
REQ-028 RUN otherwise: defaults, next RUN.
REQ-029 MEM_WAIT, mem_ready=1: default outputs (pipeline advances), next RUN; branch/load-use inputs ignored this cycle.
REQ-030 MEM_WAIT, mem_ready=0, wait counter < MEM_TIMEOUT-1: full freeze as REQ-025, wait counter +1, stay.
REQ-031 MEM_WAIT, mem_ready=0, wait counter = MEM_TIMEOUT-1: full freeze this cycle, mem_timeout <= 1, next RUN.
REQ-032 Branch and memory stall simultaneous in RUN: memory freeze wins; branch not flushed and flush_count unchanged (branch held in EX, acted on after release).
REQ-033 Load-use with ID_EX_rd = 0: no stall.
REQ-034 stall_cycles increments each non-reset cycle with PCWrite=0; both counters saturate at all-ones, never wrap.
REQ-035 mem_timeout cleared only by reset.

Reset
REQ-036 reset=1 at clk edge: state RUN, wait counter 0, stall_cycles 0, flush_count 0, mem_timeout 0.
REQ-037 While reset=1: PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write = 0, IF_ID_Flush 0, sel 1; counters do not count.
REQ-038 Reset asserted in MEM_WAIT: next cycle RUN, wait abandoned, no timeout flag.

Verification
REQ-039 Load-use: ID_EX_MemRead=1, ID_EX_rd=5, IF_ID_rs2=5 in RUN -> PCWrite=0, IF_ID_Write=0, sel=0 one cycle; stall_cycles=1.
REQ-040 Branch: EX_branch_taken=1 one cycle -> IF_ID_Flush=1, sel=0, PCWrite=1; flush_count=1.
REQ-041 Memory wait: EX_MEM_MemRead=1, mem_ready low 3 cycles then high -> 3 frozen cycles, release on 4th, state RUN, stall_cycles=3, mem_timeout=0.
REQ-042 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> 4 frozen cycles, mem_timeout=1 after 4th edge, state RUN.
REQ-043 Simultaneous: mem_busy and EX_branch_taken same cycle -> freeze, IF_ID_Flush=0, flush_count unchanged.
REQ-044 Saturation/reset: CNT_W=4, 20 load-use stalls -> stall_cycles=15; reset mid-MEM_WAIT -> all counters 0, RUN.
